bcd_cnt_segdis: RTL and testbench
=================================

Name: bcd_cnt_segdis

Overview:
- 4-digit BCD up/down counter with a multiplexed 7-segment display driver.
- Sits directly downstream of the mclk frequency divider. It consumes that divider's single-cycle tick (one mclk-wide pulse every N cycles) as its count enable.
- Drives a common-anode 4-digit display: active-low segments and active-low digit enables.
- Exposes the BCD count and carry/borrow pulses so further digits can be cascaded.

Parameters:
- SCAN_DIV, 1000, mclk cycles each digit stays lit before the scan advances (legal range 2..65535).
- LZB, 1, leading-zero blanking enable (1 = blank leading zeros; digit 0 is never blanked).

Ports:
- mclk  input  1  system clock; all logic is on posedge mclk.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  count-enable pulse from the upstream divider, sampled on posedge mclk.
- en  input  1  counting enable; tick is ignored when en=0.
- up_dn  input  1  count direction: 1 = up, 0 = down.
- clr  input  1  synchronous clear of the count.
- bcd  output  16  current count {d3,d2,d1,d0}; d0 is the least significant digit.
- co  output  1  carry-out pulse on the 9999->0000 wrap.
- bo  output  1  borrow-out pulse on the 0000->9999 wrap.
- an  output  4  digit enables, active-low; an[i] drives digit i.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
Priority per mclk edge: rst > clr > (tick & en) > hold.

Reset (rst=1 at an edge):
- d0..d3 = 0, co = bo = 0.
- Scan counter = 0, digit select sel = 0.
- an = 4'b1111, seg = 7'b1111111 (display dark).

clr:
- Sets d0..d3 = 0 and co = bo = 0.
- Does not disturb the scan counter or sel.
- A tick in the same cycle is dropped.

Counting, evaluated at an edge with tick=1 and en=1:
- Up: d0 increments. A digit at 9 goes to 0 and increments the next digit, rippling through all four digits in that same edge.
- Up at 9999: count becomes 0000 and co=1.
- Down: d0 decrements. A digit at 0 goes to 9 and decrements the next digit.
- Down at 0000: count becomes 9999 and bo=1.
- co and bo are registered: each is high for exactly the one cycle after the wrapping edge, and 0 in every other cycle.
- Counts 0001->0000 and 9998->9999 do not pulse.
- bcd is registered and shows the new value in the cycle after the tick edge.
- Digits only ever hold 0-9; no invalid BCD state is reachable.
- Consecutive ticks on back-to-back cycles each count once.
- tick held high for k cycles counts k times. Pulse shaping is the upstream block's job.

Scan:
- A free-running scan counter runs 0..SCAN_DIV-1, then wraps to 0.
- sel advances 0->1->2->3->0 on the edge where the scan counter equals SCAN_DIV-1.
- Scanning ignores en, tick, up_dn and clr.

Output register, updated every cycle after reset is released:
- an <= ~(4'b0001 << sel).
- seg <= decode(d[sel]) or blank.
- Outputs therefore lag sel and the digit values by one cycle.
- Exactly one an bit is low at a time, except while rst is asserted.

Decode (active-low, {g..a}):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

Leading-zero blanking (LZB=1):
- Digit i (i>=1) is blanked, seg=1111111, when d[i] and every higher digit are 0.
- Digit 0 always shows, so a count of 0 displays "0".
- LZB=0: every digit is always decoded.

Timing: all outputs are glitch-free registered outputs. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset: rst=1 for 3 cycles, then release -> during rst, an=1111, seg=1111111, bcd=0000, co=bo=0. The first cycle after release gives an=1110, seg=1000000 (d0 shows "0").
- Up carry ripple: load 0099 via 99 ticks with up_dn=1, en=1, then 1 more tick -> bcd=16'h0100 one cycle after the tick edge, co=0.
- Up wrap: from 9999 apply 1 tick -> bcd=0000 and co=1 for exactly one cycle. Also: ticks with en=0 leave bcd unchanged.
- Down wrap: after reset, up_dn=0, 1 tick -> bcd=9999 and bo=1 for one cycle. A second tick gives 9998 with bo=0.
- clr priority: at bcd=0042 assert clr and tick in the same cycle -> bcd=0000, no count, scan position unaffected.
- Scan/blanking with SCAN_DIV=4, LZB=1, bcd=0042:
  - an cycles 1110->1101->1011->0111, each held 4 cycles.
  - seg shows 0011001 ("4" in digit 1 position... see note below) — precisely: "2" on digit 0 is 0100100, "4" on digit 1 is 0011001.
  - Digits 2 and 3 are blank (1111111).
  - Repeat with LZB=0 -> digits 2 and 3 show 1000000.

Source files
------------

// File: rtl/bcd_cnt_segdis.sv
// 4-digit BCD up/down counter with multiplexed common-anode 7-segment scan.
// Count, carry/borrow and display outputs are registered one cycle after the edge; no backpressure.
module bcd_cnt_segdis #(
  parameter int SCAN_DIV = 1000,
  parameter bit LZB      = 1'b1
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        tick,
  input  logic        en,
  input  logic        up_dn,
  input  logic        clr,
  output logic [15:0] bcd,
  output logic        co,
  output logic        bo,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [3:0][3:0] dig;
  logic [3:0][3:0] dig_nxt;
  logic            wrap;
  logic [15:0]     scnt;
  logic [1:0]      sel;
  logic [3:0]      blank;

  assign bcd = dig;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  // Ripple through all four digits in one edge; wrap means every digit rolled over.
  always_comb begin
    logic c;
    dig_nxt = dig;
    c       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (up_dn) begin
          if (dig[i] == 4'd9) begin
            dig_nxt[i] = 4'd0;
          end else begin
            dig_nxt[i] = dig[i] + 4'd1;
            c          = 1'b0;
          end
        end else begin
          if (dig[i] == 4'd0) begin
            dig_nxt[i] = 4'd9;
          end else begin
            dig_nxt[i] = dig[i] - 4'd1;
            c          = 1'b0;
          end
        end
      end
    end
    wrap = c;
  end

  always_ff @(posedge mclk) begin
    if (rst || clr) begin
      dig <= '0;
      co  <= 1'b0;
      bo  <= 1'b0;
    end else begin
      co <= 1'b0;
      bo <= 1'b0;
      if (tick && en) begin
        dig <= dig_nxt;
        co  <= up_dn & wrap;
        bo  <= ~up_dn & wrap;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      scnt <= '0;
      sel  <= '0;
    end else if (scnt == SCAN_LAST) begin
      scnt <= '0;
      sel  <= sel + 2'd1;
    end else begin
      scnt <= scnt + 16'd1;
    end
  end

  // A digit blanks only when it and every more significant digit are zero.
  always_comb begin
    logic hz;
    blank = '0;
    hz    = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      hz       = hz & (dig[i] == 4'd0);
      blank[i] = LZB & hz;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= ~(4'b0001 << sel);
      seg <= blank[sel] ? 7'b1111111 : dec7(dig[sel]);
    end
  end

endmodule

// File: tb/tb_bcd_cnt_segdis.sv
// Directed + random bench for bcd_cnt_segdis; reference model tracks the count as an integer.
module tb_bcd_cnt_segdis;

  logic        mclk = 1'b0;
  logic        rst, tick, en, up_dn, clr;
  logic [15:0] bcd1, bcd0;
  logic        co1, bo1, co0, bo0;
  logic [3:0]  an1, an0;
  logic [6:0]  seg1, seg0;

  int total = 0;
  int bad   = 0;

  int          m_cnt = 0;
  int          m_age = 0;
  bit          m_co  = 1'b0;
  bit          m_bo  = 1'b0;
  logic [3:0]  m_an;
  logic [6:0]  m_seg1, m_seg0;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  bcd_cnt_segdis #(.SCAN_DIV(4), .LZB(1'b1)) u_lzb (
    .mclk(mclk), .rst(rst), .tick(tick), .en(en), .up_dn(up_dn), .clr(clr),
    .bcd(bcd1), .co(co1), .bo(bo1), .an(an1), .seg(seg1)
  );

  bcd_cnt_segdis #(.SCAN_DIV(4), .LZB(1'b0)) u_nolzb (
    .mclk(mclk), .rst(rst), .tick(tick), .en(en), .up_dn(up_dn), .clr(clr),
    .bcd(bcd0), .co(co0), .bo(bo0), .an(an0), .seg(seg0)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int c);
    logic [15:0] r;
    r[15:12] = 4'((c / 1000) % 10);
    r[11:8]  = 4'((c / 100) % 10);
    r[7:4]   = 4'((c / 10) % 10);
    r[3:0]   = 4'(c % 10);
    return r;
  endfunction

  function automatic logic [6:0] seg_exp(input int c, input int s, input bit lz);
    int p = 1;
    for (int k = 0; k < s; k++) p = p * 10;
    if (lz && s > 0 && c < p) return 7'b1111111;
    return segtab[(c / p) % 10];
  endfunction

  // One mclk edge: predict from pre-edge state and inputs, then compare all outputs.
  task automatic cyc();
    int s;
    s = (m_age / 4) % 4;
    if (rst) begin
      m_an   = 4'b1111;
      m_seg1 = 7'b1111111;
      m_seg0 = 7'b1111111;
    end else begin
      m_an   = ~(4'b0001 << s);
      m_seg1 = seg_exp(m_cnt, s, 1'b1);
      m_seg0 = seg_exp(m_cnt, s, 1'b0);
    end
    m_co = 1'b0;
    m_bo = 1'b0;
    if (rst) begin
      m_cnt = 0;
      m_age = 0;
    end else begin
      m_age = (m_age + 1) % 16;
      if (clr) begin
        m_cnt = 0;
      end else if (tick && en) begin
        if (up_dn) begin
          m_co  = (m_cnt == 9999);
          m_cnt = (m_cnt + 1) % 10000;
        end else begin
          m_bo  = (m_cnt == 0);
          m_cnt = (m_cnt + 9999) % 10000;
        end
      end
    end
    @(posedge mclk);
    #1;
    chk("bcd",  bcd1, to_bcd(m_cnt));
    chk("bcd0", bcd0, to_bcd(m_cnt));
    chk("co",   co1,  m_co);
    chk("bo",   bo1,  m_bo);
    chk("an",   an1,  m_an);
    chk("seg",  seg1, m_seg1);
    chk("an0",  an0,  m_an);
    chk("seg0", seg0, m_seg0);
  endtask

  initial begin
    logic [3:0] seen;
    rst = 1'b1; tick = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0;

    repeat (3) cyc();
    chk("rst_an", an1, 4'b1111);
    chk("rst_seg", seg1, 7'b1111111);
    chk("rst_bcd", bcd1, 16'h0000);
    rst = 1'b0;
    cyc();
    chk("rel_an", an1, 4'b1110);
    chk("rel_seg", seg1, 7'b1000000);

    // Back-to-back ticks up to 0099, then carry ripple into the hundreds.
    en = 1'b1; up_dn = 1'b1; tick = 1'b1;
    repeat (99) cyc();
    cyc();
    chk("ripple_bcd", bcd1, 16'h0100);
    chk("ripple_co", co1, 1'b0);

    en = 1'b0;
    repeat (5) cyc();
    chk("en0_hold", bcd1, 16'h0100);
    en = 1'b1; tick = 1'b0;

    rst = 1'b1; cyc(); rst = 1'b0;
    up_dn = 1'b0; tick = 1'b1;
    cyc();
    chk("dwrap_bcd", bcd1, 16'h9999);
    chk("dwrap_bo", bo1, 1'b1);
    cyc();
    chk("d9998_bcd", bcd1, 16'h9998);
    chk("d9998_bo", bo1, 1'b0);
    up_dn = 1'b1;
    cyc();
    chk("u9999_co", co1, 1'b0);
    cyc();
    chk("uwrap_bcd", bcd1, 16'h0000);
    chk("uwrap_co", co1, 1'b1);
    tick = 1'b0;
    cyc();
    chk("uwrap_co_drop", co1, 1'b0);

    tick = 1'b1;
    repeat (42) cyc();
    tick = 1'b0;
    cyc();
    chk("load42", bcd1, 16'h0042);

    seen = '0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      case (an1)
        4'b1110: begin seen[0] = 1'b1; chk("scan_d0", seg1, 7'b0100100); end
        4'b1101: begin seen[1] = 1'b1; chk("scan_d1", seg1, 7'b0011001); end
        4'b1011: begin seen[2] = 1'b1; chk("scan_d2_blank", seg1, 7'b1111111);
                       chk("scan_d2_nolzb", seg0, 7'b1000000); end
        4'b0111: begin seen[3] = 1'b1; chk("scan_d3_blank", seg1, 7'b1111111);
                       chk("scan_d3_nolzb", seg0, 7'b1000000); end
        default: chk("scan_onehot", an1, 4'b1110);
      endcase
    end
    chk("scan_cover", seen, 4'b1111);

    clr = 1'b1; tick = 1'b1;
    cyc();
    chk("clr_bcd", bcd1, 16'h0000);
    clr = 1'b0; tick = 1'b0;
    repeat (4) cyc();

    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      clr  = ($urandom_range(0, 79) == 0);
      tick = $urandom_range(0, 1) == 1;
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) up_dn = ~up_dn;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
